fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, PC and program-memory address width (memory depth 2^ADDR_W words).
REQ-003 SHALL have parameter QDEPTH, default 4, prefetch-queue depth (power of two, >= 2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 SHALL have port clk, input, 1, single system clock (all logic on rising edge).
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have ports prog_we (input, 1), prog_addr (input, ADDR_W) and prog_data (input, DATA_W), the program-memory write port.
REQ-008 SHALL have port run, input, 1, fetch enable.
REQ-009 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, ADDR_W), the branch/jump redirect.
REQ-010 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1), the instruction handshake.
REQ-011 SHALL have ports instr_data (output, DATA_W) and instr_pc (output, ADDR_W), the head instruction and its address.
REQ-012 SHALL have port q_level, output, $clog2(QDEPTH)+1, queue occupancy.

Function
REQ-013 SHALL hold 2^ADDR_W x DATA_W program memory; write when prog_we=1 at edge; synchronous read, 1-cycle latency, read-first on same-address collision.
REQ-014 SHALL issue one read per cycle at fetch_pc when run=1, redirect_valid=0, and q_level + in-flight reads < QDEPTH (credit rule); fetch_pc increments by 1 per issue.
REQ-015 SHALL wrap fetch_pc from 2^ADDR_W-1 to 0 with no other effect.
REQ-016 SHALL push returned data with its issuing PC into the queue; instr_valid rises 2 edges after the issuing edge.
REQ-017 SHALL present the queue head on instr_data/instr_pc whenever instr_valid=1; pop only when instr_valid & instr_ready at an edge; instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-018 SHALL allow simultaneous push and pop, including at full (q_level=QDEPTH); never overflow; instr_valid=0 when empty.
REQ-019 SHALL, on redirect_valid=1 at an edge: empty the queue, discard any in-flight read (no push), ignore a coincident pop, load fetch_pc <= redirect_pc; instr_valid=0 the following cycle; first issue at redirect_pc on the next edge if run=1.
REQ-020 SHALL stop issuing when run=0 while still draining in-flight reads and queue contents; resume at current fetch_pc when run returns to 1.
REQ-021 SHALL treat redirect_valid and prog_we in the same cycle independently (write completes, redirect applied).

Reset
REQ-022 SHALL, while reset=0, immediately force instr_valid=0, instr_data=0, instr_pc=0, q_level=0, discard in-flight reads, fetch_pc=RESET_PC.
REQ-023 SHALL leave program-memory contents unaffected by reset; mid-operation reset loses only queue and in-flight state.
REQ-024 SHALL begin issuing on the first rising edge after reset deassertion with run=1.

Structure
REQ-025 SHALL place default DATA_W, ADDR_W, QDEPTH, RESET_PC and the queue-entry type {pc, data} in shared package fetch_pkg.
REQ-026 SHALL implement the queue as sub-module fetch_queue (synchronous show-ahead FIFO with flush input, count output).

Verification
REQ-027 SHALL cover: load mem[0..5]=16'h1000..16'h1005, release reset, run=1, instr_ready=1 -> instr_valid 2 edges after first issue, then pc 0..5 with data 16'h1000..16'h1005 one per cycle.
REQ-028 SHALL cover: instr_ready=0 for 10 cycles with QDEPTH=4 -> q_level saturates at 4, no further issue, head held at pc 0 data 16'h1000; release -> no loss or duplication.
REQ-029 SHALL cover: redirect_valid=1 with redirect_pc=8'h40 while queue holds 3 entries and 1 read in flight -> instr_valid=0 next cycle, next delivered instruction has pc 8'h40, no stale entry appears.
REQ-030 SHALL cover: redirect_pc=8'hFE, ADDR_W=8 -> delivered pcs FE, FF, 00, 01.
REQ-031 SHALL cover: reset asserted mid-stream with full queue -> outputs 0 and q_level=0 immediately; after release, fetch restarts at RESET_PC with memory contents intact.
REQ-032 SHALL cover: prog_we to address 8'h03 in the same cycle it is read -> old word delivered; re-fetch after redirect to 8'h03 -> new word.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: default parameter
// values, the prefetch-queue entry layout {pc, data}, and a helper that
// sizes occupancy counters.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_QDEPTH   = 4;
    localparam int DEF_RESET_PC = 0;

    // One prefetch-queue entry at the default widths: the PC occupies the
    // upper bits and the instruction word the lower bits.  The RTL packs
    // its entries in the same {pc, data} order at any parameterisation.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] data;
    } fetch_entry_t;

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous show-ahead FIFO used as the fetch prefetch queue.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset, empties the queue
//   flush      : synchronous empty; wins over push and pop in the same cycle
//   push/data  : write one entry (accepted when not full, or full with pop)
//   pop        : remove the head entry (ignored when empty)
//   head_valid : queue non-empty
//   head_data  : head entry while head_valid, zero otherwise
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   EMPTY_CNT = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify push/pop: a push into a full queue is legal only alongside a pop.
    always_comb begin
        pop_ok_s  = pop && (count_r != EMPTY_CNT);
        push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
    end

    // Entry storage; holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_CNT;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_CNT;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Show-ahead head; forced to zero when empty so reset clears the outputs.
    always_comb begin
        head_valid = (count_r != EMPTY_CNT);
        if (head_valid) begin
            head_data = store_r[rd_ptr_r];
        end else begin
            head_data = {WIDTH{1'b0}};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: program memory, a two-stage read return
// pipeline and a credit-controlled prefetch queue.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset (memory contents kept)
//   prog_we/addr/data : program-memory write port
//   run            : fetch enable; in-flight reads and queue keep draining
//   redirect_valid/redirect_pc : flush everything and restart at redirect_pc
//   instr_valid/instr_ready    : head-of-queue handshake
//   instr_data/instr_pc        : head instruction and its address
//   q_level        : queue occupancy
// Timing: a read issued at edge N is captured by the memory at N, moves to
// the return stage at N+1 and is pushed into the queue at N+2, so
// instr_valid rises two edges after the issuing edge.
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int QDEPTH   = DEF_QDEPTH,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     run,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_W-1:0]        instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(QDEPTH):0]  q_level
);

    localparam int LVL_W     = level_w(QDEPTH);
    localparam int ENTRY_W   = ADDR_W + DATA_W;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam logic [LVL_W:0]    CREDIT_LIMIT = (LVL_W+1)'(QDEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_RESET     = ADDR_W'(RESET_PC);

    logic [DATA_W-1:0]  mem_r [MEM_DEPTH];
    logic [DATA_W-1:0]  mem_rdata_r;

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic               s1_valid_r;
    logic [ADDR_W-1:0]  s1_pc_r;
    logic               s2_valid_r;
    logic [ADDR_W-1:0]  s2_pc_r;
    logic [DATA_W-1:0]  s2_data_r;

    logic [1:0]         inflight_s;
    logic [LVL_W:0]     committed_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic               head_valid_s;
    logic [LVL_W-1:0]   level_s;

    // Issue, push and pop decisions.  Every read in flight already owns a
    // queue slot, so the queue can never overflow.  A redirect suppresses
    // issue, push and pop in its cycle.
    always_comb begin
        inflight_s   = {1'b0, s1_valid_r} + {1'b0, s2_valid_r};
        committed_s  = {1'b0, level_s} + (LVL_W+1)'(inflight_s);
        if (run && !redirect_valid && (committed_s < CREDIT_LIMIT)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        push_s       = s2_valid_r && !redirect_valid;
        pop_s        = head_valid_s && instr_ready && !redirect_valid;
        push_entry_s = {s2_pc_r, s2_data_r};
    end

    // Program memory: write port plus registered read-first read at fetch_pc.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
        mem_rdata_r <= mem_r[fetch_pc_r];
    end

    // Fetch PC and the read-return pipeline (memory stage, return stage).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r <= PC_RESET;
            s1_valid_r <= 1'b0;
            s1_pc_r    <= {ADDR_W{1'b0}};
            s2_valid_r <= 1'b0;
            s2_pc_r    <= {ADDR_W{1'b0}};
            s2_data_r  <= {DATA_W{1'b0}};
        end else if (redirect_valid) begin
            // Kill every read in flight; the next issue starts at redirect_pc.
            fetch_pc_r <= redirect_pc;
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PC_ONE;
            end
            s1_valid_r <= issue_s;
            s1_pc_r    <= fetch_pc_r;
            s2_valid_r <= s1_valid_r;
            s2_pc_r    <= s1_pc_r;
            s2_data_r  <= mem_rdata_r;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_entry_s),
        .count      (level_s)
    );

    assign instr_valid = head_valid_s;
    assign instr_data  = head_entry_s[DATA_W-1:0];
    assign instr_pc    = head_entry_s[ENTRY_W-1:DATA_W];
    assign q_level     = level_s;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit at default parameters.  The reference
// is a program-memory image plus the rule "instructions are delivered in PC
// order from the last restart point, each carrying mem[pc]".
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          run;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic [2:0]    q_level;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem_model [256];
    fetch_entry_t  got_q [$];

    fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD), .RESET_PC(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .q_level        (q_level)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record a handshake that will complete at the next rising edge, then
    // advance to the next falling edge.
    task automatic step();
        fetch_entry_t e;
        if (reset && instr_valid && instr_ready && !redirect_valid) begin
            e.pc   = instr_pc;
            e.data = instr_data;
            got_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic collect(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) step();
    endtask

    task automatic redirect_to(input logic [AW-1:0] pc, input logic run_v, input logic rdy_v);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        run            = run_v;
        instr_ready    = rdy_v;
        @(negedge clk);
        redirect_valid = 1'b0;
        got_q.delete();
    endtask

    // Check the collected stream against n sequential PCs from start_pc.
    task automatic check_stream(input string name, input int n, input logic [AW-1:0] start_pc);
        logic [AW-1:0] p;
        checks++;
        if (got_q.size() != n) begin
            failures++;
            $display("FAIL %s count got=%0d exp=%0d", name, got_q.size(), n);
        end
        p = start_pc;
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            checks++;
            if (got_q[i].pc !== p || got_q[i].data !== mem_model[p]) begin
                failures++;
                $display("FAIL %s[%0d] got pc=%h data=%h exp pc=%h data=%h",
                         name, i, got_q[i].pc, got_q[i].data, p, mem_model[p]);
            end
            p = p + 8'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
        run = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(a);
            prog_data = (a < 6) ? (16'h1000 + 16'(a)) : 16'($urandom);
            mem_model[a] = prog_data;
            @(negedge clk);
        end
        prog_we = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== 16'h0000 || instr_pc !== 8'h00 || q_level !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h pc=%h lvl=%0d exp all zero",
                     instr_valid, instr_data, instr_pc, q_level);
        end
    endtask

    task automatic test_first_fetch();
        run = 1'b1; instr_ready = 1'b1; reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== (k == 3)) begin
                failures++;
                $display("FAIL first_latency edge%0d got=%b exp=%b", k, instr_valid, (k == 3));
            end
        end
        got_q.delete();
        collect(6, 6);
        check_stream("first_fetch", 6, 8'h00);
    endtask

    task automatic test_backpressure();
        redirect_to(8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (q_level > 3'd4) begin
                failures++;
                $display("FAIL bp_overflow got=%0d exp<=4", q_level);
            end
        end
        checks++;
        if (q_level !== 3'd4 || instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 16'h1000) begin
            failures++;
            $display("FAIL bp_hold got lvl=%0d v=%b pc=%h d=%h exp 4 1 00 1000",
                     q_level, instr_valid, instr_pc, instr_data);
        end
        instr_ready = 1'b1;
        collect(8, 20);
        check_stream("bp_release", 8, 8'h00);
    endtask

    task automatic test_redirect();
        redirect_to(8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) @(negedge clk);
        checks++;
        if (q_level !== 3'd3) begin
            failures++;
            $display("FAIL redir_setup level got=%0d exp=3", q_level);
        end
        redirect_valid = 1'b1; redirect_pc = 8'h40; instr_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            checks++;
            if (instr_valid !== (k == 3)) begin
                failures++;
                $display("FAIL redir_valid edge+%0d got=%b exp=%b", k, instr_valid, (k == 3));
            end
            if (k < 3) @(negedge clk);
        end
        got_q.delete();
        collect(4, 8);
        check_stream("redirect", 4, 8'h40);
    endtask

    task automatic test_wrap();
        redirect_to(8'hFE, 1'b1, 1'b1);
        collect(4, 12);
        check_stream("wrap", 4, 8'hFE);
    endtask

    task automatic test_mid_reset();
        redirect_to(8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) @(negedge clk);
        checks++;
        if (q_level !== 3'd4) begin
            failures++;
            $display("FAIL mid_reset_full got=%0d exp=4", q_level);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr_data !== 16'h0000 || instr_pc !== 8'h00 || q_level !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got v=%b d=%h pc=%h lvl=%0d exp all zero",
                     instr_valid, instr_data, instr_pc, q_level);
        end
        @(negedge clk);
        reset = 1'b1; instr_ready = 1'b1; run = 1'b1;
        got_q.delete();
        collect(4, 12);
        check_stream("after_reset", 4, 8'h00);
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++;
            if (got_q[i].data !== 16'h1000 + 16'(i)) begin
                failures++;
                $display("FAIL mem_intact[%0d] got=%h exp=%h", i, got_q[i].data, 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] new_word;
        new_word = ~mem_model[3];
        redirect_to(8'h00, 1'b1, 1'b1);
        step(); step(); step();
        prog_we = 1'b1; prog_addr = 8'h03; prog_data = new_word;
        step();
        prog_we = 1'b0;
        collect(6, 15);
        check_stream("collision_old", 6, 8'h00);
        mem_model[3] = new_word;
        redirect_to(8'h03, 1'b1, 1'b1);
        collect(1, 6);
        check_stream("collision_new", 1, 8'h03);
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_pc;
        logic          prev_hold;
        logic          prev_redir;
        logic [AW-1:0] prev_pc;
        logic [DW-1:0] prev_data;
        exp_pc = 8'($urandom);
        redirect_to(exp_pc, 1'b1, 1'b1);
        prev_hold = 1'b0; prev_redir = 1'b0; prev_pc = 8'h00; prev_data = 16'h0000;
        for (int c = 0; c < 800; c++) begin
            if (prev_redir) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_redirect_empty cyc=%0d got=%b exp=0", c, instr_valid);
                end
            end
            if (prev_hold) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_data !== prev_data) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got v=%b pc=%h d=%h exp 1 %h %h",
                             c, instr_valid, instr_pc, instr_data, prev_pc, prev_data);
                end
            end
            checks++;
            if (q_level > 3'd4 || instr_valid !== (q_level != 3'd0)) begin
                failures++;
                $display("FAIL rnd_level cyc=%0d got lvl=%0d v=%b exp lvl<=4 v=(lvl!=0)",
                         c, q_level, instr_valid);
            end
            redirect_valid = ($urandom_range(31) == 0);
            redirect_pc    = 8'($urandom);
            instr_ready    = ($urandom_range(3) != 0);
            run            = ($urandom_range(7) != 0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr_data !== mem_model[exp_pc]) begin
                    failures++;
                    $display("FAIL rnd_deliver cyc=%0d got pc=%h d=%h exp pc=%h d=%h",
                             c, instr_pc, instr_data, exp_pc, mem_model[exp_pc]);
                end
                exp_pc = exp_pc + 8'd1;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            prev_redir = redirect_valid;
            prev_hold  = instr_valid && !instr_ready && !redirect_valid;
            prev_pc    = instr_pc;
            prev_data  = instr_data;
            @(negedge clk);
        end
        redirect_valid = 1'b0; run = 1'b1; instr_ready = 1'b1;
        got_q.delete();
        collect(1, 10);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL rnd_liveness got=%0d exp=1", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_mid_reset();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
